cache_rr_arbiter: RTL

//  Round-robin arbiter that shares one cache back-end/memory port between 2**N_REQ_W requesters.

---
 rtl/cache_rr_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cache_rr_arbiter.sv
// cache_rr_arbiter: round-robin arbiter sharing one cache back-end/memory
// port between 2**N_REQ_W requesters.
//
// Handshake: a transaction is presented while mem_valid=1. The grant and
// grant_bin outputs stay frozen until the cycle where mem_ready=1. That
// cycle is the completion cycle, and ack[owner] pulses combinationally
// during it. mem_ready is ignored while no transaction is presented.
//
// Optional feature macro: CACHE_ARB_BACK2BACK_EN.
//   defined   - a completing transaction re-arbitrates in the same cycle,
//               so back-to-back grants have no bubble.
//   undefined - one IDLE cycle follows every completed transaction.
module cache_rr_arbiter #(
  parameter int  N_REQ_W = 2,
  localparam int N       = 2 ** N_REQ_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       req,
  input  logic               mem_ready,
  output logic               mem_valid,
  output logic [N-1:0]       grant,
  output logic [N_REQ_W-1:0] grant_bin,
  output logic [N-1:0]       ack
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The FSM state is kept as a named signal so checkers can bind to it.
  state_t               state;
  state_t               state_next;
  logic [N_REQ_W-1:0]   ptr;
  logic [N_REQ_W-1:0]   ptr_next;
  logic [N-1:0]         grant_next;
  logic [N_REQ_W-1:0]   grant_bin_next;

  // The scan base is the priority pointer while idle. While busy it is
  // owner+1, which the back-to-back mode uses, so the owner scans last.
  logic [N_REQ_W-1:0]   pick_base;
  logic                 pick_found;
  logic [N_REQ_W-1:0]   pick_idx;

  // This function returns the first set request, scanning from base
  // upward and wrapping modulo N.
  function automatic logic [N_REQ_W:0] rr_pick(input logic [N-1:0]       r,
                                               input logic [N_REQ_W-1:0] base);
    logic               found;
    logic [N_REQ_W-1:0] idx;
    logic [N_REQ_W-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      idx = base + N_REQ_W'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  // The winner is selected from the current scan base.
  always_comb begin
    pick_base                = (state == BUSY) ? grant_bin + N_REQ_W'(1) : ptr;
    {pick_found, pick_idx}   = rr_pick(req, pick_base);
  end

  // This register holds the state, the frozen grant and the priority
  // pointer. It is cleared asynchronously, so the grant drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_bin <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      grant_bin <= grant_bin_next;
      ptr       <= ptr_next;
    end
  end

  // This block holds the next-state logic: arbitrate when idle, and
  // complete on mem_ready when busy.
  always_comb begin
    state_next     = state;
    grant_next     = grant;
    grant_bin_next = grant_bin;
    ptr_next       = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next     = BUSY;
          grant_bin_next = pick_idx;
          grant_next     = N'(1) << pick_idx;
        end
      end
      BUSY: begin
        // The owner's req is not looked at here, so dropping it early
        // does not cancel the transaction.
        if (mem_ready) begin
          ptr_next = grant_bin + N_REQ_W'(1);
`ifdef CACHE_ARB_BACK2BACK_EN
          if (pick_found) begin
            state_next     = BUSY;
            grant_bin_next = pick_idx;
            grant_next     = N'(1) << pick_idx;
          end else begin
            state_next     = IDLE;
            grant_bin_next = '0;
            grant_next     = '0;
          end
`else
          state_next     = IDLE;
          grant_bin_next = '0;
          grant_next     = '0;
`endif
        end
      end
      default: begin
        state_next     = IDLE;
        grant_bin_next = '0;
        grant_next     = '0;
      end
    endcase
  end

  // These are the outputs decoded from state. The grant is zero while
  // idle, so ack is also zero then.
  always_comb begin
    mem_valid = (state == BUSY);
    ack       = grant & {N{mem_ready && (state == BUSY)}};
  end

endmodule
